// File: rtl/eb_fifo_ctrl_n.sv
// Elastic-buffer FIFO controller: req/ack on both sides, any DEPTH >= 2,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
module eb_fifo_ctrl_n #(
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = $clog2(DEPTH + 1),
  parameter int AFULL  = DEPTH - 1,
  parameter int AEMPTY = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          t_req,
  output logic          t_ack,
  output logic          i_req,
  input  logic          i_ack,
  input  logic          flush,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic          wen,
  output logic          ren,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AFULL);
  localparam logic [CW-1:0] AE_C = CW'(AEMPTY);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Handshakes depend only on registered state and flush, never on the
  // partner's request, so no t_req->t_ack or i_ack->i_req path exists.
  always_comb begin
    t_ack = !flush && (count_q != FULLC);
    i_req = !flush && (count_q != '0);
    push  = t_req && t_ack;
    pop   = i_req && i_ack;
    wen   = push;
    ren   = pop;
    almost_full  = count_q >= AF_C;
    almost_empty = count_q <= AE_C;
    wr_ptr = wr_ptr_q;
    rd_ptr = rd_ptr_q;
    count  = count_q;
  end

  // Explicit wrap compare keeps non-power-of-two depths correct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST) ? '0
                 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0
                 : rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_eb_fifo_ctrl_n.sv
// Bench for eb_fifo_ctrl_n at DEPTH=5: vector table, storage model with a
// data scoreboard, and hand sequences for flush and asynchronous reset.
module tb_eb_fifo_ctrl_n;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       t_req, i_ack, flush;
  logic       t_ack, i_req, wen, ren;
  logic [2:0] wr_ptr, rd_ptr, count;
  logic       almost_full, almost_empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tr, ia, fl;
    logic [2:0] cnt, wp, rp;
    logic       ta, ir, we, re, af, ae;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] mem[5];
  logic [31:0] sbq[$];
  logic [31:0] data_ctr = 32'h100;

  eb_fifo_ctrl_n #(
    .DEPTH(5), .AFULL(4), .AEMPTY(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .t_req(t_req), .t_ack(t_ack),
    .i_req(i_req), .i_ack(i_ack),
    .flush(flush),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .wen(wen), .ren(ren),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic void addv(
    input logic tr, ia, fl,
    input int cnt, wp, rp,
    input logic ta, ir, we, re, af, ae);
    vec_t v;
    v.tr = tr; v.ia = ia; v.fl = fl;
    v.cnt = 3'(cnt); v.wp = 3'(wp); v.rp = 3'(rp);
    v.ta = ta; v.ir = ir; v.we = we; v.re = re;
    v.af = af; v.ae = ae;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic tr, ia, fl);
    @(negedge clk);
    t_req = tr;
    i_ack = ia;
    flush = fl;
    #1;
  endtask

  // Storage model: combinational read at rd_ptr, write lands at the edge.
  task automatic sb_update();
    logic [31:0] e;
    if (ren) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", mem[rd_ptr], e);
      end
    end
    if (wen) begin
      mem[wr_ptr] = data_ctr;
      sbq.push_back(data_ctr);
      data_ctr++;
    end
  endtask

  task automatic step(input logic tr, ia, fl);
    drive(tr, ia, fl);
    sb_update();
  endtask

  initial begin
    reset_n = 1'b0;
    t_req = 1'b0;
    i_ack = 1'b0;
    flush = 1'b0;
    // fill
    addv(1,0,0, 0,0,0, 1,0,1,0, 0,1);
    addv(1,0,0, 1,1,0, 1,1,1,0, 0,1);
    addv(1,0,0, 2,2,0, 1,1,1,0, 0,0);
    addv(1,0,0, 3,3,0, 1,1,1,0, 0,0);
    addv(1,0,0, 4,4,0, 1,1,1,0, 1,0);
    addv(1,0,0, 5,0,0, 0,1,0,0, 1,0);
    // drain with wrap
    addv(0,1,0, 5,0,0, 0,1,0,1, 1,0);
    addv(0,1,0, 4,0,1, 1,1,0,1, 1,0);
    addv(0,1,0, 3,0,2, 1,1,0,1, 0,0);
    addv(0,1,0, 2,0,3, 1,1,0,1, 0,0);
    addv(0,1,0, 1,0,4, 1,1,0,1, 0,1);
    addv(0,1,0, 0,0,0, 1,0,0,0, 0,1);
    // empty boundary: push only, no fall-through
    addv(1,1,0, 0,0,0, 1,0,1,0, 0,1);
    addv(1,0,0, 1,1,0, 1,1,1,0, 0,1);
    // streaming at count 2
    for (int k = 0; k < 20; k++)
      addv(1,1,0, 2,(2+k)%5,k%5, 1,1,1,1, 0,0);
    // refill, then full boundary: pop only
    addv(1,0,0, 2,2,0, 1,1,1,0, 0,0);
    addv(1,0,0, 3,3,0, 1,1,1,0, 0,0);
    addv(1,0,0, 4,4,0, 1,1,1,0, 1,0);
    addv(1,1,0, 5,0,0, 0,1,0,1, 1,0);
    addv(0,0,0, 4,0,1, 1,1,0,0, 1,0);

    // reset values
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_wr_ptr", 32'(wr_ptr), 0);
    chk("rst_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_t_ack", 32'(t_ack), 1);
    chk("rst_i_req", 32'(i_req), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_ren", 32'(ren), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].tr, tbl[i].ia, tbl[i].fl);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_wr_ptr", i), 32'(wr_ptr), 32'(tbl[i].wp));
      chk($sformatf("v%0d_rd_ptr", i), 32'(rd_ptr), 32'(tbl[i].rp));
      chk($sformatf("v%0d_t_ack", i), 32'(t_ack), 32'(tbl[i].ta));
      chk($sformatf("v%0d_i_req", i), 32'(i_req), 32'(tbl[i].ir));
      chk($sformatf("v%0d_wen", i), 32'(wen), 32'(tbl[i].we));
      chk($sformatf("v%0d_ren", i), 32'(ren), 32'(tbl[i].re));
      chk($sformatf("v%0d_afull", i), 32'(almost_full), 32'(tbl[i].af));
      chk($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
      sb_update();
    end
    chk("sb_depth", sbq.size(), 32'(count));

    // flush at count 3, wr_ptr 3
    @(negedge clk);
    reset_n = 1'b0;
    t_req = 1'b0;
    i_ack = 1'b0;
    sbq.delete();
    #2;
    chk("rst2_count", 32'(count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      chk($sformatf("fl_pre_wr%0d", k), 32'(wr_ptr), 32'(k));
    end
    drive(1, 1, 1);
    chk("fl_count", 32'(count), 3);
    chk("fl_wr_ptr", 32'(wr_ptr), 3);
    chk("fl_wen", 32'(wen), 0);
    chk("fl_ren", 32'(ren), 0);
    chk("fl_t_ack", 32'(t_ack), 0);
    chk("fl_i_req", 32'(i_req), 0);
    sbq.delete();
    drive(0, 0, 0);
    chk("fl_post_count", 32'(count), 0);
    chk("fl_post_wr_ptr", 32'(wr_ptr), 0);
    chk("fl_post_rd_ptr", 32'(rd_ptr), 0);
    chk("fl_post_t_ack", 32'(t_ack), 1);
    chk("fl_post_i_req", 32'(i_req), 0);

    // asynchronous reset mid-stream at count 4
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    drive(1, 0, 0);
    chk("ar_pre_count", 32'(count), 4);
    chk("ar_pre_wen", 32'(wen), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_wr_ptr", 32'(wr_ptr), 0);
    chk("ar_rd_ptr", 32'(rd_ptr), 0);
    sbq.delete();
    @(posedge clk);
    #1;
    chk("ar_hold_count", 32'(count), 0);
    chk("ar_hold_wr_ptr", 32'(wr_ptr), 0);
    @(negedge clk);
    t_req = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      chk($sformatf("ar_resume_wr%0d", k), 32'(wr_ptr), 32'(k));
      chk($sformatf("ar_resume_wen%0d", k), 32'(wen), 1);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0);
      chk($sformatf("ar_pop_rd%0d", k), 32'(rd_ptr), 32'(k));
    end
    drive(0, 0, 0);
    chk("end_count", 32'(count), 0);
    chk("end_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eb_fifo_ctrl_n.md
# eb_fifo_ctrl_n

Parametrised control block for an elastic-buffer FIFO with a req/ack handshake on both sides. It drives the write and read pointers and the write and read enables of an external DEPTH-entry storage array; the array has a synchronous write and a combinational read at `rd_ptr`. Relative to the fixed-depth controller it adds:
- any DEPTH ≥ 2, not only powers of two;
- use of all DEPTH entries;
- an occupancy output;
- programmable almost-full and almost-empty flags;
- a synchronous flush.

It sits between an upstream producer (t_*) and a downstream consumer (i_*) inside eb_* pipeline stages.

## Interface
Parameters:
- DEPTH, 4: number of storage entries; legal range 2..65536.
- AW, $clog2(DEPTH): pointer width (derived; do not override).
- CW, $clog2(DEPTH+1): count width (derived; do not override).
- AFULL, DEPTH-1: `almost_full` asserts when count ≥ AFULL; legal range 1..DEPTH.
- AEMPTY, 1: `almost_empty` asserts when count ≤ AEMPTY; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- t_req  in  1  upstream has data.
- t_ack  out  1  controller can accept data.
- i_req  out  1  FIFO holds data for downstream.
- i_ack  in  1  downstream accepts data.
- flush  in  1  synchronous clear of all contents.
- wr_ptr  out  AW  storage write address.
- rd_ptr  out  AW  storage read address.
- wen  out  1  storage write enable.
- ren  out  1  read pop strobe.
- count  out  CW  current occupancy, 0..DEPTH.
- almost_full  out  1  count ≥ AFULL.
- almost_empty  out  1  count ≤ AEMPTY.

## Operation
State:
- Registers are `wr_ptr`, `rd_ptr` and `count` only.
- `t_ack`, `i_req`, `wen`, `ren`, `almost_full` and `almost_empty` are combinational functions of the registered state and the inputs.

Handshake outputs:
- t_ack = !flush && (count != DEPTH).
- i_req = !flush && (count != 0).

Transfers:
- A push occurs when t_req && t_ack; wen = push.
- A pop occurs when i_req && i_ack; ren = pop.

Pointer updates:
- On push, wr_ptr ← (wr_ptr == DEPTH-1) ? 0 : wr_ptr+1.
- On pop, rd_ptr advances with the same wrap rule.
- Wrap is by explicit compare, never by natural overflow, so non-power-of-two DEPTH is correct.

Count update:
- Push and pop in the same cycle: count unchanged.
- Push only: count+1.
- Pop only: count-1.
- Neither: count held.

Overflow and underflow are impossible by construction:
- There is no push when count == DEPTH.
- There is no pop when count == 0.
- Simultaneous push and pop is legal at any 0 < count < DEPTH.
- At count == DEPTH only a pop occurs. At count == 0 only a push occurs; there is no fall-through.

Flush:
- When flush is high, next edge sets wr_ptr, rd_ptr and count to 0.
- flush overrides any push or pop in the same cycle.
- t_ack, i_req, wen and ren are forced low during the flush cycle.

Reset:
- Asserting reset_n low at any time, including mid-transfer, clears wr_ptr, rd_ptr and count to 0 immediately.
- Any in-flight handshake is discarded.

## Timing
Reset values:
- wr_ptr = 0, rd_ptr = 0, count = 0.
- t_ack = 1 (when flush is low), i_req = 0, wen = 0, ren = 0.
- almost_full = (AFULL == 0 ? 1 : 0), almost_empty = 1.

Latency:
- A push in cycle N makes i_req high in cycle N+1 when the FIFO was empty.
- A pop in cycle N frees a slot visible on t_ack in N+1.

Combinational paths:
- There is no combinational path t_req→t_ack or i_ack→i_req.
- wen depends combinationally on t_req; ren depends combinationally on i_ack.

Data and throughput:
- The read address is stable while i_req is high and no pop occurs.
- Sustained throughput is 1 transfer/cycle whenever 0 < count < DEPTH.
- almost_full and almost_empty follow count with no additional delay.

## Test plan
All scenarios use DEPTH=5, AFULL=4, AEMPTY=1.
- Fill: t_req=1, i_ack=0 from reset for 6 cycles → 5 pushes; wr_ptr sequence 1,2,3,4,0; count reaches 5; t_ack=0 on the 6th cycle; almost_full high once count=4.
- Drain with wrap: from full, i_ack=1, t_req=0 → 5 pops; rd_ptr sequence 1,2,3,4,0; i_req=0 once count=0; almost_empty high at count ≤ 1.
- Streaming: count=2, t_req=i_ack=1 for 20 cycles → count stays 2, both pointers wrap at 4→0 repeatedly, wen=ren=1 every cycle.
- Boundaries: at count=5 with t_req=i_ack=1 → pop only, count=4; at count=0 with t_req=i_ack=1 → push only, count=1, i_req=0 in that cycle.
- Flush: count=3, wr_ptr=3, pulse flush with t_req=i_ack=1 → wen=ren=0 that cycle; next cycle count=0, both pointers 0, t_ack=1.
- Async reset mid-stream: drop reset_n between edges while count=4 → all registers 0 before the next edge; after release, a normal push sequence resumes from wr_ptr=0.
